// File: rtl/fe_conc_pkg.sv
// Shared types and field geometry for the FE hit concentrator.
// Word layout: {type[1:0], payload}; payload = {fe, slot, hit} for hits.
package fe_conc_pkg;

  localparam logic [1:0] TYP_HDR = 2'b01;
  localparam logic [1:0] TYP_HIT = 2'b10;
  localparam logic [1:0] TYP_TRL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_DRAIN   = 2'd2,
    S_TRAILER = 2'd3
  } state_t;

  function automatic int fe_w(input int n_fe);
    return (n_fe < 2) ? 1 : $clog2(n_fe);
  endfunction

  function automatic int pay_w(input int n_fe, input int hit_w);
    return fe_w(n_fe) + 2 + hit_w;
  endfunction

  function automatic int out_w(input int n_fe, input int hit_w);
    return 2 + pay_w(n_fe, hit_w);
  endfunction

  function automatic int slot_lsb(input int hit_w);
    return hit_w;
  endfunction

  function automatic int fe_lsb(input int hit_w);
    return hit_w + 2;
  endfunction

endpackage

// File: rtl/hit_prio_enc.sv
// Fixed-priority encoder: lowest set request wins.
// Returns onehot grant, binary index and an any-request flag.
module hit_prio_enc #(
  parameter int N  = 12,
  parameter int IW = (N < 2) ? 1 : $clog2(N)
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // scan high to low so the lowest set bit is the last to overwrite
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IW'(i);
      end
    end
  end

endmodule

// File: rtl/fe_hit_concentrator.sv
// Snapshots FE hit slots on each bunch crossing and drains them
// as a framed event (header, hits, trailer) onto one stream.
module fe_hit_concentrator
  import fe_conc_pkg::*;
#(
  parameter int N_FE       = 4,
  parameter int HIT_W      = 13,
  parameter int TS_W       = 8,
  parameter bit EMIT_EMPTY = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          bx_strobe,
  input  logic [3*N_FE-1:0]             hit_dv,
  input  logic [3*N_FE*HIT_W-1:0]       hit_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [out_w(N_FE,HIT_W)-1:0]  out_data,
  output logic                          busy,
  output logic [15:0]                   drop_cnt
);

  localparam int NSRC  = 3 * N_FE;
  localparam int FE_W  = fe_w(N_FE);
  localparam int PAY_W = pay_w(N_FE, HIT_W);
  localparam int OUT_W = out_w(N_FE, HIT_W);
  localparam int SRC_W = $clog2(NSRC);
  localparam int CNT_W = $clog2(NSRC + 1);

  state_t              state, state_nxt;
  logic [NSRC-1:0]     pending, pend_nxt;
  logic [NSRC-1:0]     sel_grant;
  logic [HIT_W-1:0]    bank [NSRC];
  logic [TS_W-1:0]     ts_cnt, ev_ts, ev_ts_nxt;
  logic                ovf, ovf_nxt;
  logic [CNT_W-1:0]    hit_count, cnt_nxt;
  logic [OUT_W-1:0]    word_nxt;
  logic [NSRC-1:0]     grant;
  logic [SRC_W-1:0]    idx;
  logic                any;
  logic [FE_W-1:0]     fe_sel;
  logic [1:0]          slot_sel;
  logic                strobe, accept, capture, drop, load;

  assign strobe  = bx_strobe & en;
  assign accept  = out_valid & out_ready;
  assign capture = strobe &
                   ((state == S_IDLE) ||
                    ((state == S_TRAILER) && accept));
  assign drop    = strobe & ~capture;
  assign load    = ~out_valid | out_ready;
  assign busy    = (state != S_IDLE);

  // next snapshot bookkeeping: pending bits, count, overflow, timestamp
  always_comb begin
    pend_nxt  = pending;
    cnt_nxt   = hit_count;
    ovf_nxt   = ovf;
    ev_ts_nxt = ev_ts;
    if ((state == S_DRAIN) && accept) begin
      pend_nxt = pending & ~sel_grant;
      cnt_nxt  = hit_count + 1'b1;
    end
    if (capture) begin
      pend_nxt  = hit_dv;
      cnt_nxt   = '0;
      ovf_nxt   = 1'b0;
      ev_ts_nxt = ts_cnt;
    end
    if (drop) begin
      ovf_nxt = 1'b1;
    end
  end

  // lowest pending source for the word to present next
  hit_prio_enc #(
    .N  (NSRC),
    .IW (SRC_W)
  ) u_enc (
    .req   (pend_nxt),
    .grant (grant),
    .idx   (idx),
    .any   (any)
  );

  // framing state transitions
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    state_nxt = S_IDLE;
      S_HEADER:  if (accept) state_nxt = any ? S_DRAIN : S_TRAILER;
      S_DRAIN:   if (accept && !any) state_nxt = S_TRAILER;
      S_TRAILER: if (accept) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (capture) begin
      if (!EMIT_EMPTY && (hit_dv == '0)) state_nxt = S_IDLE;
      else state_nxt = S_HEADER;
    end
  end

  // build the word that the next state will present
  always_comb begin
    word_nxt = '0;
    fe_sel   = FE_W'(idx / SRC_W'(3));
    slot_sel = 2'(idx % SRC_W'(3)) + 2'd1;
    unique case (state_nxt)
      S_HEADER:  word_nxt = {TYP_HDR, PAY_W'(ev_ts_nxt)};
      S_DRAIN:   word_nxt = {TYP_HIT, fe_sel, slot_sel, bank[idx]};
      S_TRAILER: word_nxt = {TYP_TRL, ovf_nxt, (PAY_W-1)'(cnt_nxt)};
      default:   word_nxt = '0;
    endcase
  end

  // control state, counters and the registered output word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pending   <= '0;
      sel_grant <= '0;
      ts_cnt    <= '0;
      ev_ts     <= '0;
      ovf       <= 1'b0;
      hit_count <= '0;
      drop_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nxt;
      pending   <= pend_nxt;
      ev_ts     <= ev_ts_nxt;
      ovf       <= ovf_nxt;
      hit_count <= cnt_nxt;
      out_valid <= (state_nxt != S_IDLE);
      if (strobe) ts_cnt <= ts_cnt + 1'b1;
      if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 1'b1;
      if (load) begin
        out_data  <= word_nxt;
        sel_grant <= grant;
      end
    end
  end

  // payload snapshot; contents only matter where pending is set
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < NSRC; i++) begin
        bank[i] <= hit_data[i*HIT_W +: HIT_W];
      end
    end
  end

endmodule

// File: tb/tb_fe_hit_concentrator.sv
// Directed bench for fe_hit_concentrator at default parameters.
// Expected words are built by hand from the frame layout.
module tb_fe_hit_concentrator;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         bx_strobe;
  logic [11:0]  hit_dv;
  logic [155:0] hit_data;
  logic         out_valid;
  logic         out_ready;
  logic [18:0]  out_data;
  logic         busy;
  logic [15:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  fe_hit_concentrator dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .bx_strobe (bx_strobe),
    .hit_dv    (hit_dv),
    .hit_data  (hit_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] hdr(input logic [7:0] ts);
    return {2'b01, 9'd0, ts};
  endfunction

  function automatic logic [18:0] hw(input logic [1:0] fe,
                                     input logic [1:0] sl,
                                     input logic [12:0] d);
    return {2'b10, fe, sl, d};
  endfunction

  function automatic logic [18:0] trl(input logic o,
                                      input logic [3:0] n);
    return {2'b11, o, 12'd0, n};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [12:0] d);
    hit_dv[i] = 1'b1;
    hit_data[i*13 +: 13] = d;
  endtask

  logic [18:0] seq [4];

  initial begin
    rst = 1'b1;
    en = 1'b1;
    bx_strobe = 1'b0;
    hit_dv = '0;
    hit_data = '0;
    out_ready = 1'b1;
    step();
    step();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    rst = 1'b0;

    // empty event
    bx_strobe = 1'b1;
    step();
    bx_strobe = 1'b0;
    chk("e_valid", 32'(out_valid), 1);
    chk("e_hdr", 32'(out_data), 32'(hdr(8'd0)));
    chk("e_busy", 32'(busy), 1);
    step();
    chk("e_trl", 32'(out_data), 32'(trl(1'b0, 4'd0)));
    step();
    chk("e_idle_valid", 32'(out_valid), 0);
    chk("e_idle_busy", 32'(busy), 0);

    // strobe with en low is ignored
    en = 1'b0;
    bx_strobe = 1'b1;
    step();
    bx_strobe = 1'b0;
    en = 1'b1;
    chk("en_low", 32'(out_valid), 0);

    // four empty events move ts to 5
    for (int k = 1; k <= 4; k++) begin
      bx_strobe = 1'b1;
      step();
      bx_strobe = 1'b0;
      chk("pad_hdr", 32'(out_data), 32'(hdr(8'(k))));
      step();
      step();
    end

    // two hits, no backpressure
    hit_data[0 +: 13] = 13'h1555;
    set_slot(4, 13'h0ABC);
    set_slot(9, 13'h1234);
    bx_strobe = 1'b1;
    step();
    bx_strobe = 1'b0;
    chk("h_hdr", 32'(out_data), 32'(hdr(8'd5)));
    step();
    chk("h_hit0", 32'(out_data), 32'(hw(2'd1, 2'd2, 13'h0ABC)));
    step();
    chk("h_hit1", 32'(out_data), 32'(hw(2'd3, 2'd1, 13'h1234)));
    step();
    chk("h_trl", 32'(out_data), 32'(trl(1'b0, 4'd2)));
    step();
    chk("h_idle", 32'(out_valid), 0);

    // same event with stalls between every word
    seq[0] = hdr(8'd6);
    seq[1] = hw(2'd1, 2'd2, 13'h0ABC);
    seq[2] = hw(2'd3, 2'd1, 13'h1234);
    seq[3] = trl(1'b0, 4'd2);
    out_ready = 1'b0;
    bx_strobe = 1'b1;
    step();
    bx_strobe = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_word", 32'(out_data), 32'(seq[k]));
      out_ready = 1'b0;
      step();
      chk("bp_hold", 32'(out_data), 32'(seq[k]));
      out_ready = 1'b1;
      step();
    end
    chk("bp_idle", 32'(out_valid), 0);

    // drop during drain
    hit_dv = '0;
    set_slot(0, 13'h0001);
    set_slot(8, 13'h1FFF);
    bx_strobe = 1'b1;
    step();
    bx_strobe = 1'b0;
    chk("d_hdr", 32'(out_data), 32'(hdr(8'd7)));
    step();
    chk("d_hit0", 32'(out_data), 32'(hw(2'd0, 2'd1, 13'h0001)));
    bx_strobe = 1'b1;
    step();
    bx_strobe = 1'b0;
    chk("d_hit1", 32'(out_data), 32'(hw(2'd2, 2'd3, 13'h1FFF)));
    chk("d_cnt", 32'(drop_cnt), 1);
    step();
    chk("d_trl", 32'(out_data), 32'(trl(1'b1, 4'd2)));
    step();
    chk("d_idle", 32'(out_valid), 0);
    hit_dv = '0;
    bx_strobe = 1'b1;
    step();
    bx_strobe = 1'b0;
    chk("d_skip_ts", 32'(out_data), 32'(hdr(8'd9)));
    step();
    chk("d_trl2", 32'(out_data), 32'(trl(1'b0, 4'd0)));
    step();

    // strobe coincident with trailer accept
    bx_strobe = 1'b1;
    step();
    bx_strobe = 1'b0;
    chk("b_hdr", 32'(out_data), 32'(hdr(8'd10)));
    step();
    chk("b_trl", 32'(out_data), 32'(trl(1'b0, 4'd0)));
    set_slot(11, 13'h0055);
    bx_strobe = 1'b1;
    step();
    bx_strobe = 1'b0;
    chk("b_hdr2", 32'(out_data), 32'(hdr(8'd11)));
    chk("b_drop", 32'(drop_cnt), 1);
    step();
    chk("b_hit", 32'(out_data), 32'(hw(2'd3, 2'd3, 13'h0055)));
    step();
    chk("b_trl2", 32'(out_data), 32'(trl(1'b0, 4'd1)));
    step();
    chk("b_idle", 32'(out_valid), 0);

    // all slots, reset mid-drain
    for (int i = 0; i < 12; i++) set_slot(i, 13'(32'h100 + i));
    bx_strobe = 1'b1;
    step();
    bx_strobe = 1'b0;
    chk("r_hdr", 32'(out_data), 32'(hdr(8'd12)));
    step();
    chk("r_hit0", 32'(out_data), 32'(hw(2'd0, 2'd1, 13'h100)));
    step();
    chk("r_hit1", 32'(out_data), 32'(hw(2'd0, 2'd2, 13'h101)));
    rst = 1'b1;
    #1;
    chk("r_valid", 32'(out_valid), 0);
    chk("r_drop", 32'(drop_cnt), 0);
    chk("r_busy", 32'(busy), 0);
    step();
    rst = 1'b0;
    hit_dv = '0;
    bx_strobe = 1'b1;
    step();
    bx_strobe = 1'b0;
    chk("r_hdr0", 32'(out_data), 32'(hdr(8'd0)));
    step();
    chk("r_trl0", 32'(out_data), 32'(trl(1'b0, 4'd0)));
    step();
    chk("r_idle", 32'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fe_hit_concentrator.md
Name: fe_hit_concentrator

Overview:
Event-building controller that sequences readout of N_FE front-end chips. Each chip presents up to 3 hit slots (dv + 13-bit {stub[7:0],bend[4:0]}) per bunch crossing. On each bunch-crossing strobe the block snapshots all slots, then drains them as one framed event (header, hits, trailer) onto a single valid/ready stream toward the trigger-tower logic. It arbitrates the shared output link among the N_FE×3 hit sources.

Parameters:
N_FE, 4, number of FE chips (2..16)
HIT_W, 13, hit payload width
TS_W, 8, bunch-crossing timestamp width (TS_W <= HIT_W+FE_W+2)
EMIT_EMPTY, 1, 1 = emit header+trailer for events with no hits; 0 = suppress them
Derived: FE_W = clog2(N_FE); NSRC = 3*N_FE; OUT_W = 2+FE_W+2+HIT_W (19 at defaults)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  capture enable; bx_strobe ignored while low
bx_strobe  in  1  one-cycle pulse per bunch crossing; hit inputs valid this cycle
hit_dv  in  NSRC  slot valids, index = fe*3 + (slot-1)
hit_data  in  NSRC*HIT_W  slot payloads, same indexing
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts when out_valid & out_ready
out_data  out  OUT_W  {type[1:0], payload}
busy  out  1  high whenever state != IDLE
drop_cnt  out  16  dropped bunch crossings, saturating

Behaviour:
- Reset (async): state IDLE, out_valid=0, out_data=0, busy=0, drop_cnt=0, ts_cnt=0, pending=0, ovf=0, hit_count=0.
- ts_cnt: increments mod 2^TS_W on every bx_strobe&en, captured or dropped.
- Capture: if bx_strobe&en and state is IDLE, or state is TRAILER with the trailer accepted this cycle, then:
  - pending<=hit_dv, data bank<=hit_data, ev_ts<=ts_cnt (pre-increment), ovf<=0, hit_count<=0.
  - Go to HEADER, unless EMIT_EMPTY=0 and hit_dv==0, in which case stay/return IDLE.
- Drop: bx_strobe&en in any other cycle -> snapshot unchanged; drop_cnt+1 (saturates at FFFF); ovf<=1 for the event in progress.
- FSM:
  - IDLE: out_valid=0.
  - HEADER: out_data={2'b01, zero-ext ev_ts}. On accept -> DRAIN if pending!=0, else TRAILER.
  - DRAIN: out_data={2'b10, fe, slot(1..3), hit}. Source = lowest set index of pending (fixed priority, fe0 slot1 first). On accept clear that pending bit, hit_count+1. Last bit cleared -> TRAILER.
  - TRAILER: out_data={2'b11, ovf, zero-ext hit_count}. On accept -> IDLE, or straight to HEADER on a simultaneous capture.
- Handshake: out_valid is registered and asserted in HEADER/DRAIN/TRAILER. out_data is held stable until accepted. No combinational path from out_ready to out_valid.
- Latency: strobe on edge t -> header valid from cycle t+1. Zero-backpressure event with k hits takes k+2 cycles; the next event can start back-to-back.
- Reset mid-event: frame is aborted and no trailer is sent; the downstream resynchronises on the next header.
- Slot numbering in words is 1..3; slot 0 is never emitted.

Decomposition:
- Package fe_conc_pkg: type codes (HDR=2'b01, HIT=2'b10, TRL=2'b11), state enum, widths FE_W/OUT_W, field offsets.
- Sub-module hit_prio_enc: NSRC-bit request vector -> onehot grant, index, any flag. Purely combinational, reused by other link mergers.

Test Plan:
- Reset then strobe with hit_dv=0, EMIT_EMPTY=1, ready=1 -> 01_00 header, then trailer {11,0,count 0}; busy low after 2 cycles.
- ts_cnt=5; fe1 slot2=0x0ABC, fe3 slot1=0x1234 -> header ts 5; hit{fe1,slot2,0ABC}; hit{fe3,slot1,1234}; trailer count 2, ovf 0.
- Same event with out_ready toggling 1/0 -> identical word sequence; out_data stable while stalled; no duplicates.
- Second strobe during DRAIN -> drop_cnt=1, trailer ovf=1, ts of the next captured event skips one value.
- Strobe in the same cycle as trailer accept -> new header on the next cycle, drop_cnt unchanged.
- All 12 slots valid, then assert rst mid-DRAIN -> out_valid=0 immediately, drop_cnt=0; a later strobe frames normally from ts 0.
